// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared window geometry and scatter FSM state encoding
package npu_pkg;

    localparam int WIN_SIZE   = 9;
    localparam int FILL_CNT_W = 4;

    // PEND exists only in the double-buffered build
    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/window_scatter_9_win_bank.sv
// rtl/window_scatter_9_win_bank.sv - nine-element register bank with indexed write and whole-bank load
module win_bank
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  logic [FILL_CNT_W-1:0]         i_wr_idx,
    input  logic [BIT_DEPTH-1:0]          i_wr_data,
    input  logic                          i_load_en,
    input  logic [WIN_SIZE*BIT_DEPTH-1:0] i_load_data,
    output logic [WIN_SIZE*BIT_DEPTH-1:0] o_bank_data
);

    logic [BIT_DEPTH-1:0] r_elem [WIN_SIZE];

    // Whole-bank load has priority; otherwise only the addressed element is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN_SIZE; k++) r_elem[k] <= '0;
        end else if (i_load_en) begin
            for (int k = 0; k < WIN_SIZE; k++) r_elem[k] <= i_load_data[k*BIT_DEPTH +: BIT_DEPTH];
        end else if (i_wr_en) begin
            for (int k = 0; k < WIN_SIZE; k++) begin
                if (i_wr_idx == FILL_CNT_W'(k)) r_elem[k] <= i_wr_data;
            end
        end
    end

    // Flatten the bank, element 0 in the low bits
    always_comb begin
        o_bank_data = '0;
        for (int k = 0; k < WIN_SIZE; k++) o_bank_data[k*BIT_DEPTH +: BIT_DEPTH] = r_elem[k];
    end

endmodule

// File: rtl/window_scatter_9.sv
// rtl/window_scatter_9.sv - serial-to-3x3 window scatter; WINDOW_SCATTER_DOUBLE_BUF_EN adds a hold bank
module window_scatter_9
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [BIT_DEPTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_DEPTH-1:0]  out1,
    output logic [BIT_DEPTH-1:0]  out2,
    output logic [BIT_DEPTH-1:0]  out3,
    output logic [BIT_DEPTH-1:0]  out4,
    output logic [BIT_DEPTH-1:0]  out5,
    output logic [BIT_DEPTH-1:0]  out6,
    output logic [BIT_DEPTH-1:0]  out7,
    output logic [BIT_DEPTH-1:0]  out8,
    output logic [BIT_DEPTH-1:0]  out9,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [FILL_CNT_W-1:0] fill_cnt
);

    localparam int W = WIN_SIZE * BIT_DEPTH;

    state_t                r_state;
    logic [FILL_CNT_W-1:0] r_fill_cnt;
    logic                  w_accept;
    logic                  w_last_beat;
    logic [W-1:0]          w_win;

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = w_accept && (r_fill_cnt == FILL_CNT_W'(WIN_SIZE - 1));
    assign fill_cnt    = r_fill_cnt;

    // Beat counter: clr aborts the fill, the ninth beat wraps it back to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (clr) begin
            r_fill_cnt <= '0;
        end else if (w_last_beat) begin
            r_fill_cnt <= '0;
        end else if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

`ifdef WINDOW_SCATTER_DOUBLE_BUF_EN

    logic         w_xfer;
    logic         w_load;
    logic [W-1:0] w_fill_data;
    logic [BIT_DEPTH-1:0] w_ninth;

    // Filling continues while a window is held; only a second complete window stalls input
    assign in_ready  = (r_state != PEND) && !clr;
    assign win_valid = (r_state != FILL);
    assign w_xfer    = win_valid && win_ready;

    // Ninth beat is bypassed straight into the hold bank unless the copy is deferred by PEND
    assign w_ninth = (r_state == PEND) ? w_fill_data[W-1 -: BIT_DEPTH] : in_data;
    assign w_load  = (w_last_beat && ((r_state == FILL) || w_xfer))
                   || ((r_state == PEND) && win_ready);

    // FILL: hold empty; FULL: hold occupied; PEND: hold occupied and fill bank complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            case (r_state)
                FILL:    if (w_last_beat) r_state <= FULL;
                FULL:    if (w_last_beat) r_state <= w_xfer ? FULL : PEND;
                         else if (win_ready) r_state <= FILL;
                PEND:    if (win_ready) r_state <= FULL;
                default: r_state <= FILL;
            endcase
        end
    end

    win_bank #(.BIT_DEPTH(BIT_DEPTH)) u_fill_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_fill_cnt),
        .i_wr_data   (in_data),
        .i_load_en   (1'b0),
        .i_load_data ({W{1'b0}}),
        .o_bank_data (w_fill_data)
    );

    win_bank #(.BIT_DEPTH(BIT_DEPTH)) u_hold_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (1'b0),
        .i_wr_idx    ({FILL_CNT_W{1'b0}}),
        .i_wr_data   ({BIT_DEPTH{1'b0}}),
        .i_load_en   (w_load),
        .i_load_data ({w_ninth, w_fill_data[W-BIT_DEPTH-1:0]}),
        .o_bank_data (w_win)
    );

`else

    assign in_ready  = (r_state == FILL) && !clr;
    assign win_valid = (r_state == FULL);

    // Single bank: fill nine beats, then hold until the consumer takes the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            case (r_state)
                FILL:    if (w_last_beat) r_state <= FULL;
                FULL:    if (win_ready) r_state <= FILL;
                default: r_state <= FILL;
            endcase
        end
    end

    win_bank #(.BIT_DEPTH(BIT_DEPTH)) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_fill_cnt),
        .i_wr_data   (in_data),
        .i_load_en   (1'b0),
        .i_load_data ({W{1'b0}}),
        .o_bank_data (w_win)
    );

`endif

    assign out1 = w_win[0*BIT_DEPTH +: BIT_DEPTH];
    assign out2 = w_win[1*BIT_DEPTH +: BIT_DEPTH];
    assign out3 = w_win[2*BIT_DEPTH +: BIT_DEPTH];
    assign out4 = w_win[3*BIT_DEPTH +: BIT_DEPTH];
    assign out5 = w_win[4*BIT_DEPTH +: BIT_DEPTH];
    assign out6 = w_win[5*BIT_DEPTH +: BIT_DEPTH];
    assign out7 = w_win[6*BIT_DEPTH +: BIT_DEPTH];
    assign out8 = w_win[7*BIT_DEPTH +: BIT_DEPTH];
    assign out9 = w_win[8*BIT_DEPTH +: BIT_DEPTH];

endmodule

// File: doc/window_scatter_9.md
# window_scatter_9

Serial-to-window scatter for the NPU convolution datapath. It accepts a stream of BIT_DEPTH-bit pixel or weight values over a valid/ready handshake and writes them, in order, into nine held output registers. It presents them as one 3x3 window with its own valid/ready handshake. It is the loading end of the nine-input window bus that the 9:1 window selector reads.

## Interface
- BIT_DEPTH, 8, width of each element
- WIN_SIZE, 9, elements per window; fixed at 9, not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous abort of the in-progress fill
- in_data  input  BIT_DEPTH  stream element
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out1..out9  output  BIT_DEPTH each  window elements; out1 holds the first accepted beat, out9 the ninth
- win_valid  output  1  out1..out9 hold a complete window
- win_ready  input  1  consumer takes the window
- fill_cnt  output  4  beats accepted into the current fill, 0..8

## Operation
- A beat is accepted when in_valid && in_ready. Accepted beat k (fill_cnt==k) is written to element k+1; fill_cnt then increments.
- State FILL:
  - in_ready = !clr.
  - Accepting the beat with fill_cnt==8 sets fill_cnt to 0 and moves to FULL, with win_valid=1 from the next cycle.
- State FULL:
  - in_ready = 0 and win_valid = 1.
  - When win_ready is high, return to FILL next cycle with win_valid = 0.
- A window transfer is win_valid && win_ready. out1..out9 are never cleared by a transfer; they keep their last values.
- clr:
  - In FILL: fill_cnt goes to 0 and no beat is accepted that cycle.
  - In FULL: no effect.
  - Data registers are never cleared by clr.
- fill_cnt never exceeds 8. An element is written only by an accepted beat.

## Timing
- Reset values: in_ready=1, win_valid=0, fill_cnt=0, out1..out9=0, state FILL.
- Latency: win_valid rises on the cycle after the ninth beat is accepted, and out9 is valid in that same cycle.
- Single-buffer throughput: minimum 10 cycles per window (9 beats plus 1 ack cycle). in_ready rises on the cycle after the transfer.
- win_ready may be high before win_valid; it is ignored in FILL.
- Reset asserted mid-fill or mid-hold returns all outputs to their reset values immediately; partial data is discarded.
- clr in the same cycle as in_valid: clr wins. in_ready is low, so the upstream source must hold the beat.

## Configuration
- WINDOW_SCATTER_DOUBLE_BUF_EN defined: separate fill bank and hold bank; out1..out9 come from the hold bank.
  - in_ready stays high in FULL, so the next window fills while the current one is held.
  - On the ninth accept: if the hold bank is empty or transferring in that cycle, the fill bank plus the bypassed ninth beat are copied to the hold bank and win_valid is 1 next cycle.
  - Otherwise the block enters PEND with in_ready=0. On the next transfer, the copy happens and in_ready returns the following cycle while win_valid stays 1.
  - Sustained throughput is one window per 9 cycles. clr affects the fill bank only.
- Not defined: single bank, FILL/FULL only, behaviour exactly as in Operation.

## Structure
- Shared package npu_pkg holds:
  - WIN_SIZE=9
  - FILL_CNT_W=4
  - state enum {FILL, FULL, PEND} (PEND used only when double buffering is enabled)
- Sub-module win_bank: nine BIT_DEPTH registers with indexed write enable and a whole-bank parallel load.
  - Instantiated once when single-buffered.
  - Instantiated twice (fill and hold) when WINDOW_SCATTER_DOUBLE_BUF_EN is defined.

## Test plan
- Reset mid-fill: assert rst_n=0 after 4 accepted beats -> all outputs 0 and in_ready=1 asynchronously; no win_valid follows.
- Basic load: send 0x11,0x22,...,0x99 with win_ready=1 -> win_valid=1 one cycle after the last beat with out1=0x11 … out9=0x99, then win_valid=0 and in_ready=1 on the next cycle.
- Backpressure: win_ready=0 for 20 cycles after the window completes -> win_valid held at 1, outputs stable, in_ready=0 (single buffer), no beats lost.
- clr mid-fill: 5 beats, then clr together with in_valid, then 9 beats 0xA0..0xA8 -> clr-cycle beat not accepted; out1=0xA0 … out9=0xA8; fill_cnt returns to 0 on clr.
- Double buffer (macro defined): continuous in_valid over 27 beats with win_ready=1 -> three windows, one win_valid pulse every 9 cycles, in_ready never low. Repeat with win_ready=0 -> PEND after 18 beats, in_ready=0 until the first transfer.
